wishbone_to_ahb: RTL and testbench

//  Wishbone classic (B3) slave to AHB-Lite master bridge, the reverse of our AHB->WB bridge.

---
 rtl/ahb_wb_pkg.sv | 45 ++++
 rtl/wishbone_to_ahb.sv | 172 +++++++++++++++++
 tb/tb_wishbone_to_ahb.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_wb_pkg.sv
// Shared AHB-Lite encodings and helpers for the Wishbone <-> AHB bridges.
package ahb_wb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StResp,
        StDrain
    } w2a_state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] hsize;
        logic [1:0] addr_lo;
    } sel_dec_t;

    // Only naturally aligned byte, halfword and word lane patterns map onto an AHB size.
    function automatic sel_dec_t sel_to_size(input logic [3:0] sel);
        sel_dec_t dec;
        dec = '{valid: 1'b1, hsize: HSIZE_BYTE, addr_lo: 2'b00};
        case (sel)
            4'b1111: dec.hsize = HSIZE_WORD;
            4'b0011: dec.hsize = HSIZE_HALF;
            4'b1100: begin
                dec.hsize   = HSIZE_HALF;
                dec.addr_lo = 2'b10;
            end
            4'b0001: dec.addr_lo = 2'b00;
            4'b0010: dec.addr_lo = 2'b01;
            4'b0100: dec.addr_lo = 2'b10;
            4'b1000: dec.addr_lo = 2'b11;
            default: dec.valid = 1'b0;
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/wishbone_to_ahb.sv
// Wishbone classic slave to AHB-Lite master bridge: single transfers, one outstanding,
// HREADY-stretched data phases and ERROR responses mapped onto wb_ack/wb_err.
module wishbone_to_ahb #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter logic [3:0]  HPROT_VAL      = 4'b0011,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  wb_cyc,
    input  logic                  wb_stb,
    input  logic                  wb_we,
    input  logic [ADDR_WIDTH-1:0] wb_adr,
    input  logic [DATA_WIDTH-1:0] wb_dat_w,
    input  logic [3:0]            wb_sel,
    output logic [DATA_WIDTH-1:0] wb_dat_r,
    output logic                  wb_ack,
    output logic                  wb_err,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic                  HMASTLOCK,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic [1:0]            HRESP
);
    import ahb_wb_pkg::*;

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] CntMax = '1;
    localparam logic [CntW-1:0] TimeoutLast =
        (TIMEOUT_CYCLES == 0) ? '0 : CntW'(TIMEOUT_CYCLES - 1);

    w2a_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
    logic [1:0]            htrans_q, htrans_d;
    logic                  hwrite_q, hwrite_d;
    logic [2:0]            hsize_q, hsize_d;
    logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] dat_r_q, dat_r_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  abort_q, abort_d;
    sel_dec_t              dec;
    logic                  timeout;
    logic                  aborted;
    logic                  unused_bits;

    assign unused_bits = ^{wb_adr[1:0], HRESP[1]};

    always_comb begin
        state_d  = state_q;
        haddr_d  = haddr_q;
        htrans_d = htrans_q;
        hwrite_d = hwrite_q;
        hsize_d  = hsize_q;
        hwdata_d = hwdata_q;
        wdata_d  = wdata_q;
        dat_r_d  = dat_r_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        cnt_d    = cnt_q;
        abort_d  = abort_q;
        timeout  = 1'b0;
        dec      = sel_to_size(wb_sel);

        if (state_q inside {StAddr, StData}) begin
            if (cnt_q != CntMax) cnt_d = cnt_q + CntW'(1);
            if (!wb_cyc) abort_d = 1'b1;
            timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == TimeoutLast);
        end
        // An abandoned cycle still has to finish on AHB, but the initiator hears nothing back.
        aborted = abort_q | ~wb_cyc;

        unique case (state_q)
            StIdle: begin
                if (wb_cyc && wb_stb) begin
                    if (dec.valid) begin
                        state_d  = StAddr;
                        htrans_d = HTRANS_NONSEQ;
                        haddr_d  = {wb_adr[ADDR_WIDTH-1:2], dec.addr_lo};
                        hwrite_d = wb_we;
                        hsize_d  = dec.hsize;
                        wdata_d  = wb_dat_w;
                        cnt_d    = '0;
                        abort_d  = 1'b0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StAddr: begin
                if (HREADY || timeout) begin
                    htrans_d = HTRANS_IDLE;
                    hwdata_d = wdata_q;
                    state_d  = timeout ? StDrain : StData;
                    err_d    = timeout & ~aborted;
                end
            end
            StData: begin
                if (HREADY) begin
                    state_d = aborted ? StIdle : StResp;
                    if (!aborted) begin
                        if (HRESP[0]) begin
                            err_d = 1'b1;
                        end else begin
                            ack_d = 1'b1;
                            if (!hwrite_q) dat_r_d = HRDATA;
                        end
                    end
                end else if (timeout) begin
                    state_d = StDrain;
                    err_d   = ~aborted;
                end
            end
            StResp:  state_d = StIdle;
            StDrain: if (HREADY) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= StIdle;
            haddr_q  <= '0;
            htrans_q <= HTRANS_IDLE;
            hwrite_q <= 1'b0;
            hsize_q  <= '0;
            hwdata_q <= '0;
            wdata_q  <= '0;
            dat_r_q  <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            haddr_q  <= haddr_d;
            htrans_q <= htrans_d;
            hwrite_q <= hwrite_d;
            hsize_q  <= hsize_d;
            hwdata_q <= hwdata_d;
            wdata_q  <= wdata_d;
            dat_r_q  <= dat_r_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            abort_q  <= abort_d;
        end
    end

    assign wb_dat_r  = dat_r_q;
    assign wb_ack    = ack_q;
    assign wb_err    = err_q;
    assign HADDR     = haddr_q;
    assign HTRANS    = htrans_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HWDATA    = hwdata_q;
    assign HBURST    = 3'b000;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_wishbone_to_ahb.sv
// Directed bench for wishbone_to_ahb: per-scenario expected timelines built from transfer
// parameters (wait states, response, lane pattern) and compared every cycle.
module tb_wishbone_to_ahb;
    localparam int unsigned TO   = 8;
    localparam int          MAXK = 32;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_adr, wb_dat_w, wb_dat_r;
    logic [3:0]  wb_sel;
    logic        wb_ack, wb_err;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS, HRESP;
    logic        HWRITE, HMASTLOCK, HREADY;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

    always #5 HCLK = ~HCLK;

    wishbone_to_ahb #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .HPROT_VAL(4'b0011), .TIMEOUT_CYCLES(TO)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_dat_w(wb_dat_w), .wb_sel(wb_sel), .wb_dat_r(wb_dat_r),
        .wb_ack(wb_ack), .wb_err(wb_err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADY(HREADY), .HRESP(HRESP)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cur_k = 0;
    bit chk_on = 1'b0;

    // Scenario script (cycle k sits between clock edge k-1 and edge k; edge 0 samples stb).
    logic        s_cyc[MAXK];
    logic        s_hready[MAXK];
    logic [1:0]  s_hresp[MAXK];
    logic        s_we;
    logic [31:0] s_adr, s_dat, s_rdata;
    logic [3:0]  s_sel;
    // Expected timeline.
    logic [1:0]  e_trans[MAXK];
    logic        e_ack[MAXK], e_err[MAXK], e_wd[MAXK];
    logic [31:0] e_datr[MAXK];
    logic [31:0] e_haddr;
    logic [2:0]  e_hsize;
    logic [31:0] m_datr = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (k=%0d): got %h, want %h", name, cur_k, act, exp);
        end
    endtask

    // Lane pattern -> AHB size/offset from popcount and lowest set lane.
    function automatic bit sel_model(input logic [3:0] sel, output logic [2:0] size,
                                     output logic [1:0] lo);
        int n;
        int first;
        n = 0;
        first = -1;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                n++;
                if (first < 0) first = i;
            end
        end
        lo   = (first < 0) ? 2'b00 : 2'(first);
        size = (n == 4) ? 3'd2 : (n == 2) ? 3'd1 : 3'd0;
        if (n == 2 && (first == 0 || first == 2)) return sel[first+1] == 1'b1;
        return (n == 1) || (n == 4);
    endfunction

    task automatic fill_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                             input logic [31:0] dat, input logic [31:0] rdata, input int wa,
                             input int wd, input bit errr, input int drop, output int len);
        bit v;
        bit ok_read;
        logic [2:0] sz;
        logic [1:0] lo;
        int ka;
        v = sel_model(sel, sz, lo);
        s_we = we; s_adr = adr; s_sel = sel; s_dat = dat; s_rdata = rdata;
        e_haddr = {adr[31:2], lo};
        e_hsize = sz;
        ka  = v ? 3 + wa + wd : 1;
        len = ka + 3;
        ok_read = v && !we && !errr && drop == 0;
        for (int k = 0; k < MAXK; k++) begin
            s_cyc[k]    = (drop == 0) ? (k <= ka) : (k < drop);
            s_hready[k] = !(v && ((k >= 1 && k <= wa) || (k >= 2 + wa && k <= 1 + wa + wd)));
            s_hresp[k]  = (v && errr && (k == 1 + wa + wd || k == 2 + wa + wd)) ? 2'b01 : 2'b00;
            e_trans[k]  = (v && k >= 1 && k <= 1 + wa) ? 2'b10 : 2'b00;
            e_ack[k]    = v && !errr && drop == 0 && k == ka;
            e_err[k]    = (!v || errr) && drop == 0 && k == ka;
            e_wd[k]     = v && we && k >= 2 + wa && k <= 2 + wa + wd;
            e_datr[k]   = (ok_read && k >= ka) ? rdata : m_datr;
        end
        if (ok_read) m_datr = rdata;
    endtask

    // Slave never ready until cycle rel; stb kept high through the drain to show it is ignored.
    task automatic fill_timeout(input int rel, output int len);
        s_we = 1'b1; s_adr = 32'h5000; s_sel = 4'b1111; s_dat = 32'h55AA55AA; s_rdata = 32'h0;
        e_haddr = 32'h5000;
        e_hsize = 3'd2;
        len = rel + 3;
        for (int k = 0; k < MAXK; k++) begin
            s_cyc[k]    = k < rel;
            s_hready[k] = (k == 0) || (k >= rel);
            s_hresp[k]  = 2'b00;
            e_trans[k]  = (k >= 1 && k <= int'(TO)) ? 2'b10 : 2'b00;
            e_ack[k]    = 1'b0;
            e_err[k]    = k == int'(TO) + 1;
            e_wd[k]     = 1'b0;
            e_datr[k]   = m_datr;
        end
    endtask

    task automatic play(input int len);
        for (int k = 0; k < len; k++) begin
            wb_cyc = s_cyc[k]; wb_stb = s_cyc[k]; wb_we = s_we; wb_adr = s_adr;
            wb_dat_w = s_dat; wb_sel = s_sel;
            HREADY = s_hready[k]; HRESP = s_hresp[k]; HRDATA = s_rdata;
            cur_k = k;
            chk_on = 1'b1;
            @(posedge HCLK);
            #2;
        end
        chk_on = 1'b0;
        wb_cyc = 1'b0; wb_stb = 1'b0; HREADY = 1'b1; HRESP = 2'b00;
    endtask

    always @(negedge HCLK) begin
        if (chk_on) begin
            check("htrans", 32'(HTRANS), 32'(e_trans[cur_k]));
            check("wb_ack", 32'(wb_ack), 32'(e_ack[cur_k]));
            check("wb_err", 32'(wb_err), 32'(e_err[cur_k]));
            check("wb_dat_r", wb_dat_r, e_datr[cur_k]);
            check("hburst", 32'(HBURST), 32'h0);
            check("hprot", 32'(HPROT), 32'h3);
            check("hmastlock", 32'(HMASTLOCK), 32'h0);
            if (e_trans[cur_k] == 2'b10) begin
                check("haddr", HADDR, e_haddr);
                check("hsize", 32'(HSIZE), 32'(e_hsize));
                check("hwrite", 32'(HWRITE), 32'(s_we));
            end
            if (e_wd[cur_k]) check("hwdata", HWDATA, s_dat);
        end
    end

    initial begin
        int len;
        HRESETn = 1'b0;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_adr = '0; wb_dat_w = '0; wb_sel = '0;
        HREADY = 1'b1; HRESP = 2'b00; HRDATA = '0;
        #3;
        check("rst_htrans", 32'(HTRANS), 32'h0);
        check("rst_haddr", HADDR, 32'h0);
        check("rst_ack", 32'(wb_ack), 32'h0);
        check("rst_err", 32'(wb_err), 32'h0);
        check("rst_dat_r", wb_dat_r, 32'h0);
        check("rst_hprot", 32'(HPROT), 32'h3);
        #9 HRESETn = 1'b1;
        @(posedge HCLK);
        #2;

        // Zero-wait word write: ack in cycle 3.
        fill_xfer(1'b1, 32'h1000, 4'b1111, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0, 0, len);
        check("t1_ack_cycle", 32'(len - 3), 32'd3);
        play(len);
        // Upper-halfword read with three data-phase wait states.
        fill_xfer(1'b0, 32'h2002, 4'b1100, 32'h0, 32'h1234ABCD, 0, 3, 1'b0, 0, len);
        check("t2_haddr_model", e_haddr, 32'h2002);
        play(len);
        check("t2_dat_r", wb_dat_r, 32'h1234ABCD);
        // Byte write with two address-phase wait states.
        fill_xfer(1'b1, 32'h3000, 4'b0100, 32'h00AB0000, 32'h0, 2, 0, 1'b0, 0, len);
        check("t2b_haddr_model", e_haddr, 32'h3002);
        play(len);
        // Two-cycle ERROR on a write.
        fill_xfer(1'b1, 32'h4000, 4'b0011, 32'h0000BEEF, 32'h0, 0, 1, 1'b1, 0, len);
        play(len);
        // Non-contiguous lanes: immediate error, no AHB transfer.
        fill_xfer(1'b1, 32'h4400, 4'b0101, 32'h0, 32'h0, 0, 0, 1'b0, 0, len);
        play(len);
        // Cycle dropped mid-transfer: AHB side finishes, Wishbone sees nothing.
        fill_xfer(1'b0, 32'h4800, 4'b1111, 32'h0, 32'h99999999, 1, 2, 1'b0, 2, len);
        play(len);
        check("abort_dat_r", wb_dat_r, 32'h1234ABCD);
        // Timeout with HREADY stuck low, released at cycle 12.
        fill_timeout(12, len);
        play(len);
        // Word read after the drain proves the bridge came back to idle.
        fill_xfer(1'b0, 32'h5004, 4'b1111, 32'h0, 32'hA5A5F00D, 0, 0, 1'b0, 0, len);
        play(len);

        // Reset asserted during a stretched data phase.
        fill_xfer(1'b1, 32'h6000, 4'b1111, 32'hCAFEF00D, 32'h0, 0, 5, 1'b0, 0, len);
        play(3);
        HRESETn = 1'b0;
        #1;
        check("mid_rst_htrans", 32'(HTRANS), 32'h0);
        check("mid_rst_haddr", HADDR, 32'h0);
        check("mid_rst_hwdata", HWDATA, 32'h0);
        check("mid_rst_hsize", 32'(HSIZE), 32'h0);
        check("mid_rst_dat_r", wb_dat_r, 32'h0);
        check("mid_rst_ack", 32'(wb_ack), 32'h0);
        m_datr = 32'h0;
        @(posedge HCLK);
        #3 HRESETn = 1'b1;
        @(posedge HCLK);
        #2;
        fill_xfer(1'b1, 32'h7000, 4'b1111, 32'h0BADC0DE, 32'h0, 0, 0, 1'b0, 0, len);
        play(len);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
